// File: rtl/t5_dwb_wbuf_if.sv
// CPU data-bus and memory-bus bundle for the posted-write buffer.
// slave is the buffer's view; master is the CPU/memory side that drives it.
interface t5_dwb_wbuf_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [XLEN-3:0] dwb_adr;
    logic [XLEN-1:0] dwb_dto;
    logic [3:0]      dwb_sel;
    logic            dwb_stb;
    logic            dwb_wre;
    logic            dwb_ack;
    logic [XLEN-1:0] dwb_dti;
    logic            dwb_err;

    logic [XLEN-3:0] mem_adr;
    logic [XLEN-1:0] mem_dto;
    logic [3:0]      mem_sel;
    logic            mem_stb;
    logic            mem_wre;
    logic            mem_ack;
    logic [XLEN-1:0] mem_dti;

    logic [LW-1:0]   buf_lvl;

    modport slave (
        input  dwb_adr, dwb_dto, dwb_sel, dwb_stb, dwb_wre, mem_ack, mem_dti,
        output dwb_ack, dwb_dti, dwb_err, mem_adr, mem_dto, mem_sel, mem_stb, mem_wre, buf_lvl
    );

    modport master (
        output dwb_adr, dwb_dto, dwb_sel, dwb_stb, dwb_wre, mem_ack, mem_dti,
        input  dwb_ack, dwb_dti, dwb_err, mem_adr, mem_dto, mem_sel, mem_stb, mem_wre, buf_lvl
    );
endinterface

// File: rtl/t5_dwb_wbuf.sv
// Posted-write buffer between the CPU data bus and a single-outstanding memory port.
// Reads wait for the FIFO to drain, so memory always sees program order.
//   state | meaning
//   IDLE  | no memory transaction; start a write if FIFO non-empty, else a pending read
//   WR    | FIFO head on the memory bus, waiting for mem_ack (pop on ack)
//   GAP   | one idle strobe cycle after a write
//   RD    | latched read request on the memory bus, waiting for mem_ack
//   RSP   | read data returned to the CPU with dwb_ack
module t5_dwb_wbuf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    t5_dwb_wbuf_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [2:0] {IDLE, WR, GAP, RD, RSP} state_t;

    state_t          state;

    logic [XLEN-3:0] fifo_adr [DEPTH];
    logic [XLEN-1:0] fifo_dto [DEPTH];
    logic [3:0]      fifo_sel [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   lvl;

    logic            rd_pend;
    logic [XLEN-3:0] rd_adr;
    logic [3:0]      rd_sel;

    logic            ack_q;
    logic            err_q;
    logic [XLEN-1:0] dti_q;
    logic [XLEN-3:0] m_adr;
    logic [XLEN-1:0] m_dto;
    logic [3:0]      m_sel;
    logic            m_stb;
    logic            m_wre;

    logic            sel_ok;
    logic            req;
    logic            push;
    logic            pop;
    logic            start_wr;
    logic            start_rd;

    function automatic logic sel_legal(input logic [3:0] s);
        case (s)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: sel_legal = 1'b1;
            default:                                   sel_legal = 1'b0;
        endcase
    endfunction

    // A pending read blocks the CPU, so its held strobe must not be re-sampled.
    always_comb begin
        sel_ok   = sel_legal(bus.dwb_sel);
        req      = bus.dwb_stb && !ack_q && !rd_pend;
        push     = req && bus.dwb_wre && sel_ok && (lvl != FULL_LVL);
        pop      = (state == WR) && bus.mem_ack;
        start_wr = ((state == IDLE) || (state == GAP)) && (lvl != '0);
        start_rd = ((state == IDLE) || (state == GAP)) && (lvl == '0) && rd_pend;
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_adr[wr_ptr] <= bus.dwb_adr;
            fifo_dto[wr_ptr] <= bus.dwb_dto;
            fifo_sel[wr_ptr] <= bus.dwb_sel;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lvl     <= '0;
            rd_pend <= 1'b0;
            rd_adr  <= '0;
            rd_sel  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dti_q   <= '0;
            m_adr   <= '0;
            m_dto   <= '0;
            m_sel   <= '0;
            m_stb   <= 1'b0;
            m_wre   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;

            if (req) begin
                if (!sel_ok) begin
                    ack_q <= 1'b1;
                    err_q <= 1'b1;
                end else if (bus.dwb_wre) begin
                    if (push) begin
                        ack_q <= 1'b1;
                    end
                end else begin
                    rd_pend <= 1'b1;
                    rd_adr  <= bus.dwb_adr;
                    rd_sel  <= bus.dwb_sel;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + LW'(1);
                2'b01:   lvl <= lvl - LW'(1);
                default: lvl <= lvl;
            endcase

            case (state)
                IDLE: begin
                    if (start_wr) begin
                        state <= WR;
                    end else if (start_rd) begin
                        state <= RD;
                    end
                end
                WR: begin
                    if (bus.mem_ack) begin
                        state <= GAP;
                        m_stb <= 1'b0;
                        m_wre <= 1'b0;
                    end
                end
                GAP: begin
                    if (start_wr) begin
                        state <= WR;
                    end else if (start_rd) begin
                        state <= RD;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD: begin
                    if (bus.mem_ack) begin
                        state   <= RSP;
                        m_stb   <= 1'b0;
                        dti_q   <= bus.mem_dti;
                        ack_q   <= 1'b1;
                        rd_pend <= 1'b0;
                    end
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (start_wr) begin
                m_stb <= 1'b1;
                m_wre <= 1'b1;
                m_adr <= fifo_adr[rd_ptr];
                m_dto <= fifo_dto[rd_ptr];
                m_sel <= fifo_sel[rd_ptr];
            end else if (start_rd) begin
                m_stb <= 1'b1;
                m_wre <= 1'b0;
                m_adr <= rd_adr;
                m_dto <= '0;
                m_sel <= rd_sel;
            end
        end
    end

    assign bus.dwb_ack = ack_q;
    assign bus.dwb_err = err_q;
    assign bus.dwb_dti = dti_q;
    assign bus.mem_adr = m_adr;
    assign bus.mem_dto = m_dto;
    assign bus.mem_sel = m_sel;
    assign bus.mem_stb = m_stb;
    assign bus.mem_wre = m_wre;
    assign bus.buf_lvl = lvl;

endmodule
